// File: rtl/serial_subtractor_if.sv
// Start/busy/done operand and result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (output start, a, b, input busy, done, diff, bout, ovf, zero);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf, zero);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-subtractor cell.
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | shifting one bit per edge through the cell
// DONE  | one-cycle done pulse, results valid
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb, b_msb;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, ovf_q, zero_q;

    logic             a0, b0, d, br_next;
    logic [WIDTH-1:0] d_sh_next;
    logic             last_bit;

    assign a0        = a_sh[0];
    assign b0        = b_sh[0];
    assign d         = a0 ^ b0 ^ br;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign d_sh_next = {d, d_sh[WIDTH-1:1]};
    assign last_bit  = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Operand MSBs are kept aside because the shift registers are consumed by the last edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_sh_next;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_q <= d_sh_next;
                        bout_q <= br_next;
                        ovf_q  <= (a_msb != b_msb) & (d != a_msb);
                        zero_q <= (d_sh_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [W-1:0] last_diff;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {zero, ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, sd;
        logic [W-1:0] dd;
        logic ov, bo, z;
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        dd = x - y;
        ov = (sd > 127) || (sd < -128);
        bo = (int'(x) < int'(y));
        z  = (dd == 0);
        return {z, ov, bo, dd};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W+2:0] e;
        e = model(x, y);
        check({tag, ".diff"}, bus.diff, e[W-1:0]);
        check({tag, ".bout"}, bus.bout, e[W]);
        check({tag, ".ovf"},  bus.ovf,  e[W+1]);
        check({tag, ".zero"}, bus.zero, e[W+2]);
        last_diff = e[W-1:0];
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        check({tag, ".busy_rise"}, bus.busy, 1'b1);
        check({tag, ".hold_diff"}, bus.diff, last_diff);
        wait_done(n);
        check({tag, ".latency"}, n, W);
        check_result(tag, x, y);
        @(posedge clk); #1;
        check({tag, ".busy_fall"}, bus.busy, 1'b0);
        check({tag, ".done_fall"}, bus.done, 1'b0);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        last_diff = '0;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #2;
        check("reset.busy", bus.busy, 1'b0);
        check("reset.done", bus.done, 1'b0);
        check("reset.diff", bus.diff, 8'h00);
        check("reset.flags", {bus.bout, bus.ovf, bus.zero}, 3'b000);
        @(negedge clk); rst = 1'b0;

        run_op("p100_37", 8'd100, 8'd37);
        check("p100_37.const", bus.diff, 8'h3F);
        run_op("p05_0a", 8'h05, 8'h0A);
        run_op("p80_01", 8'h80, 8'h01);
        run_op("p00_ff", 8'h00, 8'hFF);
        run_op("p5a_5a", 8'h5A, 8'h5A);
        run_op("p7f_80", 8'h7F, 8'h80);

        // start pulses while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h30; bus.b = 8'h10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n);
        check("ign.latency", n, W - 4);
        check_result("ign", 8'h30, 8'h10);
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("ign.busy_after_done", bus.busy, 1'b0);
        check("ign.done_once", bus.done, 1'b0);
        check("ign.diff_kept", bus.diff, 8'h20);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ign.accept_idle", bus.busy, 1'b1);
        wait_done(n);
        check("ign2.latency", n, W);
        check_result("ign2", 8'hFF, 8'h00);
        @(posedge clk); #1;

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst.busy", bus.busy, 1'b0);
        check("arst.done", bus.done, 1'b0);
        check("arst.diff", bus.diff, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        last_diff = '0;
        run_op("post_rst", 8'h10, 8'h01);
        check("post_rst.const", bus.diff, 8'h0F);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand", ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor. Computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell.
- It is the subtract-direction counterpart of the team's ripple adder datapath and shares that datapath's operand and flag conventions.
- Uses a start/busy/done handshake so a controller FSM can issue operations and collect results.
- Outputs: difference, borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits (must be at least 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only while busy=0.
- a  input  WIDTH  minuend; captured on the edge that accepts start.
- b  input  WIDTH  subtrahend; captured on the edge that accepts start.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- bout  output  1  final borrow; 1 if and only if a < b unsigned.
- ovf  output  1  signed overflow of a - b.
- zero  output  1  1 if and only if diff == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE.
  - busy, done, diff, bout, ovf and zero all 0.
  - Internal shift registers, borrow and bit counter cleared.
  - No partial result is ever published.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: load a into A_sh and b into B_sh, set br=0 and cnt=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Cell inputs: a0=A_sh[0], b0=B_sh[0].
  - Difference bit: d = a0 ^ b0 ^ br.
  - Next borrow: br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift A_sh and B_sh right; shift d into the MSB of D_sh; cnt increments.
  - On the edge with cnt == WIDTH-1 (last bit), register:
    - diff = final D_sh;
    - bout = br_next;
    - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured a and b;
    - zero = (diff == 0);
    - then set done=1 and go to DONE.
- DONE:
  - done=1 for exactly this one cycle, busy=1.
  - The next edge returns to IDLE and clears done.
- Latency:
  - Start accepted at edge k; done is high in the cycle following edge k+WIDTH.
  - busy is high from after edge k through the done cycle.
  - Total period: WIDTH+1 cycles per operation.
  - Earliest next accept is edge k+WIDTH+2.
- start while busy=1 (RUN or DONE, including the done cycle) is ignored. It is not queued, and in-flight operands are unaffected.
- a and b may change freely after the accept edge; only the captured copies are used.
- diff, bout, ovf and zero hold their last values until the next operation completes. They are not cleared when a new start is accepted.
- Arithmetic is modulo 2^WIDTH. bout is the unsigned borrow; ovf is the signed interpretation. Both flags are valid for every operand pair.
- The subtract cell is combinational inside the module. No external adder instance is required.

Test Plan:
- WIDTH=8, a=100, b=37, start pulsed 1 cycle.
  -> busy rises next cycle; done high exactly 8 cycles after the accept edge, for 1 cycle; diff=63 (0x3F), bout=0, ovf=0, zero=0; busy low the cycle after done.
- a=0x05, b=0x0A -> diff=0xFB, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x00, b=0xFF -> diff=0x01, bout=1, ovf=0.
- a=0x5A, b=0x5A -> diff=0x00, bout=0, ovf=0, zero=1.
- Start a=0x30, b=0x10; pulse start with a=0xFF, b=0x00 at cycle 3 of RUN and again on the done cycle.
  -> single done, diff=0x20, no second operation.
  - Then start at the first cycle with busy=0 -> accepted.
- Start a=0x77, b=0x11; assert rst mid-cycle after 4 RUN edges.
  -> busy, done and diff go to 0 immediately, without waiting for a clock edge.
  - After rst is released, a=0x10, b=0x01 -> diff=0x0F in 8 cycles.
